vga_sync_pulse_gen: RTL and testbench

//  Free-running VGA timing source at the head of the video path.

---
 rtl/vga_sync_if.sv | 26 ++
 rtl/vga_sync_pulse_gen.sv | 92 +++++++++
 tb/tb_vga_sync_pulse_gen.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Raster timing bundle between the VGA sync source and its consumers.
// The sync source drives the master side; the enable comes from downstream.
interface vga_sync_if;
    logic       enable_i;
    logic       Hsync_o;
    logic       Vsync_o;
    logic [9:0] col_count_o;
    logic [9:0] row_count_o;
    logic       active_o;
    logic       line_start_o;
    logic       frame_start_o;

    modport master (
        input  enable_i,
        output Hsync_o, Vsync_o,
        output col_count_o, row_count_o,
        output active_o, line_start_o, frame_start_o
    );

    modport slave (
        output enable_i,
        input  Hsync_o, Vsync_o,
        input  col_count_o, row_count_o,
        input  active_o, line_start_o, frame_start_o
    );
endinterface

// File: rtl/vga_sync_pulse_gen.sv
// Free-running VGA raster scanner: active-video Hsync/Vsync markers,
// aligned pixel counts and line/frame start strobes, one register of latency.
module vga_sync_pulse_gen #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    vga_sync_if.master vga
);
    if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024 ||
        ACTIVE_COLS < 1 || ACTIVE_ROWS < 1 ||
        ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS) begin : g_bad_params
        $error("vga_sync_pulse_gen: invalid raster parameters");
    end

    localparam logic [9:0] HLAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] VLAST = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACOLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] AROWS = 10'(ACTIVE_ROWS);

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [9:0] col_q, col_d, row_q, row_d;
    logic       hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic       ls_q, ls_d, fs_q, fs_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vga.enable_i) begin
            if (h_q == HLAST) begin
                h_d = '0;
                v_d = (v_q == VLAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Outputs describe the pixel the counters point at before advancing.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        if (vga.enable_i) begin
            col_d = h_q;
            row_d = v_q;
            hs_d  = (h_q < ACOLS);
            vs_d  = (v_q < AROWS);
            ls_d  = (h_q == '0);
            fs_d  = (h_q == '0) && (v_q == '0);
        end
        act_d = hs_d & vs_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q   <= '0;
            v_q   <= '0;
            col_q <= '0;
            row_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            act_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            col_q <= col_d;
            row_q <= row_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign vga.Hsync_o       = hs_q;
    assign vga.Vsync_o       = vs_q;
    assign vga.col_count_o   = col_q;
    assign vga.row_count_o   = row_q;
    assign vga.active_o      = act_q;
    assign vga.line_start_o  = ls_q;
    assign vga.frame_start_o = fs_q;
endmodule

// File: tb/tb_vga_sync_pulse_gen.sv
// Bench for vga_sync_pulse_gen: full-size and tiny rasters checked every
// cycle against a linear pixel-index model, plus literal timing checks.
module tb_vga_sync_pulse_gen;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vga_sync_if m_if ();
    vga_sync_if s_if ();

    vga_sync_pulse_gen u_main (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vga     (m_if)
    );

    vga_sync_pulse_gen #(
        .TOTAL_COLS  (10),
        .TOTAL_ROWS  (6),
        .ACTIVE_COLS (8),
        .ACTIVE_ROWS (4)
    ) u_small (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vga     (s_if)
    );

    typedef struct {
        int pos;
        int col;
        int row;
        bit h;
        bit v;
        bit a;
        bit ls;
        bit fs;
    } mdl_t;

    mdl_t mm, sm, sm_prev;

    // Model: a linear pixel index walks the raster; each enabled clock shows it.
    function automatic mdl_t step(mdl_t m, bit en, int tc, int tr, int ac, int ar);
        mdl_t n = m;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (en) begin
            n.col = m.pos % tc;
            n.row = m.pos / tc;
            n.h   = n.col < ac;
            n.v   = n.row < ar;
            n.ls  = n.col == 0;
            n.fs  = m.pos == 0;
            n.pos = (m.pos + 1) % (tc * tr);
        end
        n.a = n.h && n.v;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm <= '{default: 0};
            sm <= '{default: 0};
        end else begin
            mm <= step(mm, m_if.enable_i, 800, 525, 640, 480);
            sm <= step(sm, s_if.enable_i, 10, 6, 8, 4);
        end
    end

    // Downstream sync-to-count stage: restarts on the Vsync rising edge.
    logic       ds_vs, ds_ok;
    logic [9:0] ds_c, ds_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_vs <= 1'b0;
            ds_ok <= 1'b0;
            ds_c  <= '0;
            ds_r  <= '0;
        end else begin
            ds_vs <= s_if.Vsync_o;
            if (s_if.Vsync_o && !ds_vs) begin
                ds_c  <= '0;
                ds_r  <= '0;
                ds_ok <= 1'b1;
            end else if (ds_c == 10'd9) begin
                ds_c <= '0;
                ds_r <= (ds_r == 10'd5) ? '0 : ds_r + 10'd1;
            end else begin
                ds_c <= ds_c + 10'd1;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string p, logic [9:0] c, logic [9:0] r, logic h,
                       logic v, logic a, logic ls, logic fs, mdl_t e);
        chk({p, "_col"}, 32'(c), e.col);
        chk({p, "_row"}, 32'(r), e.row);
        chk({p, "_hs"}, 32'(h), 32'(e.h));
        chk({p, "_vs"}, 32'(v), 32'(e.v));
        chk({p, "_act"}, 32'(a), 32'(e.a));
        chk({p, "_ls"}, 32'(ls), 32'(e.ls));
        chk({p, "_fs"}, 32'(fs), 32'(e.fs));
    endtask

    always @(negedge clk) begin
        cmp("main", m_if.col_count_o, m_if.row_count_o, m_if.Hsync_o,
            m_if.Vsync_o, m_if.active_o, m_if.line_start_o,
            m_if.frame_start_o, mm);
        cmp("small", s_if.col_count_o, s_if.row_count_o, s_if.Hsync_o,
            s_if.Vsync_o, s_if.active_o, s_if.line_start_o,
            s_if.frame_start_o, sm);
        if (ds_ok) begin
            chk("ds_col", 32'(ds_c), sm_prev.col);
            chk("ds_row", 32'(ds_r), sm_prev.row);
        end
        sm_prev = sm;
    end

    task automatic wait_pix(string nm, int c, int r);
        int k = 0;
        while (!(m_if.col_count_o == 10'(c) && m_if.row_count_o == 10'(r))
               && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(k < 20000), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_hi, ls_n, vs_hi, fs_n, rises, fs_first, fs_second, k;
        logic [9:0] prow;
        logic pvs;
        rst_n = 1'b0;
        m_if.enable_i = 1'b1;
        s_if.enable_i = 1'b1;

        // 1: reset then first pixel
        repeat (5) begin
            @(negedge clk);
            chk("t1_rst_col", 32'(m_if.col_count_o), 0);
            chk("t1_rst_vs", 32'(m_if.Vsync_o), 0);
            chk("t1_rst_fs", 32'(m_if.frame_start_o), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_col", 32'(m_if.col_count_o), 0);
        chk("t1_row", 32'(m_if.row_count_o), 0);
        chk("t1_hs", 32'(m_if.Hsync_o), 1);
        chk("t1_vs", 32'(m_if.Vsync_o), 1);
        chk("t1_fs", 32'(m_if.frame_start_o), 1);

        // 2: one full line
        hs_hi = 0;
        ls_n = 0;
        for (int i = 0; i < 800; i++) begin
            if (m_if.Hsync_o) hs_hi++;
            if (m_if.line_start_o) ls_n++;
            @(negedge clk);
        end
        chk("t2_hs_hi", hs_hi, 640);
        chk("t2_hs_lo", 800 - hs_hi, 160);
        chk("t2_ls_cnt", ls_n, 1);
        chk("t2_wrap_col", 32'(m_if.col_count_o), 0);
        chk("t2_wrap_row", 32'(m_if.row_count_o), 1);
        chk("t2_wrap_ls", 32'(m_if.line_start_o), 1);

        // random enable gaps, checked by the per-cycle model
        repeat (2000) begin
            @(negedge clk);
            m_if.enable_i = ($urandom_range(0, 7) != 0);
        end
        @(negedge clk);
        m_if.enable_i = 1'b1;

        // 4: enable drop at (639, 10)
        wait_pix("t4_reach", 639, 10);
        m_if.enable_i = 1'b0;
        repeat (7) begin
            @(negedge clk);
            chk("t4_hold_col", 32'(m_if.col_count_o), 639);
            chk("t4_hold_row", 32'(m_if.row_count_o), 10);
            chk("t4_hold_hs", 32'(m_if.Hsync_o), 1);
            chk("t4_no_ls", 32'(m_if.line_start_o), 0);
            chk("t4_no_fs", 32'(m_if.frame_start_o), 0);
        end
        m_if.enable_i = 1'b1;
        @(negedge clk);
        chk("t4_resume_col", 32'(m_if.col_count_o), 640);
        chk("t4_resume_hs", 32'(m_if.Hsync_o), 0);

        // 5: asynchronous reset mid-frame
        wait_pix("t5_reach", 300, 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_col", 32'(m_if.col_count_o), 0);
        chk("t5_async_row", 32'(m_if.row_count_o), 0);
        chk("t5_async_hs", 32'(m_if.Hsync_o), 0);
        chk("t5_async_vs", 32'(m_if.Vsync_o), 0);
        chk("t5_async_act", 32'(m_if.active_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_col", 32'(m_if.col_count_o), 0);
        chk("t5_row", 32'(m_if.row_count_o), 0);
        chk("t5_fs", 32'(m_if.frame_start_o), 1);
        chk("t5_hs", 32'(m_if.Hsync_o), 1);

        // 3/6: frame timing on the tiny raster
        k = 0;
        while (!s_if.frame_start_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t3_fs_seen", 32'(k < 200), 1);
        vs_hi = 0;
        fs_n = 0;
        rises = 0;
        fs_first = -1;
        fs_second = -1;
        pvs = s_if.Vsync_o;
        prow = s_if.row_count_o;
        for (int i = 0; i < 120; i++) begin
            if (s_if.Vsync_o) vs_hi++;
            if (s_if.frame_start_o) begin
                fs_n++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (i > 0 && s_if.Vsync_o && !pvs) begin
                rises++;
                chk("t3_rise_prow", 32'(prow), 5);
                chk("t3_rise_row", 32'(s_if.row_count_o), 0);
            end
            pvs = s_if.Vsync_o;
            prow = s_if.row_count_o;
            @(negedge clk);
        end
        chk("t3_fs_cnt", fs_n, 2);
        chk("t3_fs_period", fs_second - fs_first, 60);
        chk("t3_vs_hi", vs_hi, 80);
        chk("t3_vs_lo", 120 - vs_hi, 40);
        chk("t3_rises", rises, 1);
        chk("t6_ds_armed", 32'(ds_ok), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
